// File: rtl/priv_key_gen.sv
// Bit-serial extended-Euclid private exponent generator: d = e^-1 mod phi, or ok=0 when no inverse exists.
// Optional macro PRIV_KEY_CYCLE_CNT_EN adds a saturating 'cycles' latency output.
module priv_key_gen #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   e,
  input  logic [2*WIDTH-1:0] phi,
  output logic [2*WIDTH-1:0] d,
  output logic               ok,
  output logic               finish,
  output logic               busy
`ifdef PRIV_KEY_CYCLE_CNT_EN
  ,
  output logic [31:0]        cycles
`endif
);
  localparam int N  = 2 * WIDTH;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_MUL, S_UPD} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r0_q, r0_d, r1_q, r1_d, t0_q, t0_d, t1_q, t1_d;
  logic [N-1:0]  quo_q, quo_d, phi_q, phi_d, d_q, d_d;
  logic [N:0]    rem_q, rem_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d, fin_q, fin_d;

  logic [N:0]    rem_sh, acc_dbl, acc_red, acc_add, acc_sum, t_dif;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      phi_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      ok_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      phi_q   <= phi_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      ok_q    <= ok_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    phi_d   = phi_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    ok_d    = ok_q;
    fin_d   = 1'b0;

    // Restoring-divide step: remainder stays below r1, so its top bit is always clear.
    rem_sh  = (rem_q << 1) | {{N{1'b0}}, quo_q[N-1]};
    // Shift-add modular multiply step; acc < phi holds before and after.
    acc_dbl = acc_q << 1;
    acc_red = (acc_dbl >= {1'b0, phi_q}) ? acc_dbl - {1'b0, phi_q} : acc_dbl;
    acc_add = acc_red + (quo_q[N-1] ? {1'b0, t1_q} : '0);
    acc_sum = (acc_add >= {1'b0, phi_q}) ? acc_add - {1'b0, phi_q} : acc_add;
    t_dif   = {1'b0, t0_q} + {1'b0, phi_q} - acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r0_d    = phi;
          r1_d    = {{WIDTH{1'b0}}, e};
          t0_d    = '0;
          t1_d    = N'(1);
          phi_d   = phi;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (phi_q < N'(2)) begin
          fin_d   = 1'b1;
          ok_d    = 1'b0;
          d_d     = '0;
          state_d = S_IDLE;
        end else if (r1_q == '0) begin
          fin_d   = 1'b1;
          ok_d    = (r0_q == N'(1));
          d_d     = (r0_q == N'(1)) ? t0_q : '0;
          state_d = S_IDLE;
        end else begin
          rem_d   = '0;
          acc_d   = '0;
          quo_d   = r0_q;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        quo_d = {quo_q[N-2:0], 1'b0};
        if (rem_sh >= {1'b0, r1_q}) begin
          rem_d    = rem_sh - {1'b0, r1_q};
          quo_d[0] = 1'b1;
        end else begin
          rem_d = rem_sh;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        quo_d = {quo_q[N-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          cnt_d   = '0;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        r0_d    = r1_q;
        r1_d    = N'(rem_q);
        t0_d    = t1_q;
        t1_d    = (t0_q >= N'(acc_q)) ? t0_q - N'(acc_q) : N'(t_dif);
        state_d = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d      = d_q;
  assign ok     = ok_q;
  assign finish = fin_q;
  assign busy   = (state_q != S_IDLE);

`ifdef PRIV_KEY_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, cycles_q, cycles_d, cyc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      cycles_q  <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      cycles_q  <= cycles_d;
    end
  end

  // cyc_cnt holds the number of edges already elapsed since (and including) the start edge.
  always_comb begin
    cyc_inc   = (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : cyc_cnt_q + 32'd1;
    cyc_cnt_d = cyc_cnt_q;
    cycles_d  = cycles_q;
    if (state_q == S_IDLE) begin
      if (start) cyc_cnt_d = 32'd1;
    end else begin
      cyc_cnt_d = cyc_inc;
    end
    if (fin_d) cycles_d = cyc_inc;
  end

  assign cycles = cycles_q;
`endif
endmodule

// File: tb/tb_priv_key_gen.sv
// Table-driven + scoreboard bench for priv_key_gen (WIDTH=8): result, ok and finish latency in edges.
module tb_priv_key_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  e_i = '0;
  logic [15:0] phi_i = '0;
  logic [15:0] d;
  logic        ok, finish, busy;
`ifdef PRIV_KEY_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  priv_key_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .e(e_i), .phi(phi_i),
    .d(d), .ok(ok), .finish(finish), .busy(busy)
`ifdef PRIV_KEY_CYCLE_CNT_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int phi;
    int e;
    int d;
    int ok;
    int lat;
  } vec_t;

  typedef struct {
    int d;
    int ok;
    int lat;
    int mark;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  exp_t sb[$];
  vec_t tbl [10];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: signed extended Euclid on integers.
  function automatic void model(input int p, input int ee, output int dd, output int okk, output int lat);
    longint r0, r1, t0, t1, q, tmp;
    int k;
    if (p < 2) begin
      dd = 0; okk = 0; lat = 1;
      return;
    end
    r0 = p; r1 = ee; t0 = 0; t1 = 1; k = 0;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      k++;
    end
    okk = (r0 == 1) ? 1 : 0;
    dd  = (okk == 1) ? int'(((t0 % p) + p) % p) : 0;
    lat = 1 + k * 34;
  endfunction

  // Scoreboard consumer: every finish pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && finish) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_finish: got finish=1 expected no finish (d=%0d)", d);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("d", d, x.d);
        chk("ok", ok, x.ok);
        chk("latency", edge_cnt - x.mark - 1, x.lat);
`ifdef PRIV_KEY_CYCLE_CNT_EN
        chk("cycles", cycles, x.lat + 1);
`endif
      end
    end
  end

  // Call at a negedge; start is sampled on the following posedge (edge 0).
  task automatic launch_now(input int p, input int ee, input int ed, input int eok, input int elat);
    exp_t x;
    phi_i = 16'(p);
    e_i   = 8'(ee);
    start = 1'b1;
    x.d = ed; x.ok = eok; x.lat = elat; x.mark = edge_cnt;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input int p, input int ee, input int ed, input int eok, input int elat);
    @(negedge clk);
    launch_now(p, ee, ed, eok, elat);
  endtask

  // Returns at the negedge where finish is high.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    if (finish) seen = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (i != 0 || !finish) @(negedge clk);
      if (finish) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: got no finish expected finish within 3000 cycles", name);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, rok, rlat, rp, re;
    tbl[0] = '{3120, 17, 2753, 1, 137};
    tbl[1] = '{160, 3, 107, 1, 69};
    tbl[2] = '{3120, 15, 0, 0, 35};
    tbl[3] = '{3120, 1, 1, 1, 35};
    tbl[4] = '{3120, 0, 0, 0, 1};
    tbl[5] = '{1, 5, 0, 0, 1};
    tbl[6] = '{10, 17, 3, 1, 171};
    tbl[7] = '{256, 255, 255, 1, 69};
    tbl[8] = '{0, 7, 0, 0, 1};
    tbl[9] = '{2, 1, 1, 1, 35};

    repeat (3) @(negedge clk);
    chk("rst_d", d, 0);
    chk("rst_ok", ok, 0);
    chk("rst_finish", finish, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].phi, tbl[i].e, tbl[i].d, tbl[i].ok, tbl[i].lat);
      if (tbl[i].lat > 1) chk("busy_running", busy, 1);
      wait_done("table");
      @(negedge clk);
      chk("busy_after", busy, 0);
    end

    for (int i = 0; i < 6; i++) begin
      rp = int'($urandom_range(2, 65535));
      re = int'($urandom_range(0, 255));
      model(rp, re, rd, rok, rlat);
      launch(rp, re, rd, rok, rlat);
      wait_done("random");
    end

    // Start pulsed mid-run is ignored; no second finish may follow.
    launch(3120, 17, 2753, 1, 137);
    repeat (20) @(negedge clk);
    phi_i = 16'd160; e_i = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    repeat (80) @(negedge clk);
    chk("ignored_busy", busy, 0);
    chk("ignored_d_held", d, 2753);

    // Back-to-back: start asserted during the finish cycle.
    launch(160, 3, 107, 1, 69);
    wait_done("b2b_first");
    launch_now(3120, 17, 2753, 1, 137);
    chk("b2b_busy", busy, 1);
    wait_done("b2b_second");

    // Reset mid-DIV abandons the run and clears outputs immediately.
    launch(3120, 17, 2753, 1, 137);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_d", d, 0);
    chk("midrst_ok", ok, 0);
    chk("midrst_finish", finish, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(160, 3, 107, 1, 69);
    wait_done("after_rst");
    repeat (3) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
